// File: rtl/lut_sched_pkg.sv
// rtl/lut_sched_pkg.sv - shared types and default geometry for the LUT layer scheduler
package lut_sched_pkg;

    localparam int NEURONS_DEF = 8;
    localparam int FEATS_DEF   = 16;
    localparam int FEAT_W_DEF  = 2;
    localparam int FANIN_DEF   = 3;
    localparam int OUT_W_DEF   = 2;

    localparam int AW_DEF = FANIN_DEF * FEAT_W_DEF;
    localparam int NW_DEF = $clog2(NEURONS_DEF);
    localparam int IW_DEF = $clog2(FEATS_DEF);

    localparam logic CFG_SEL_TABLE = 1'b0;
    localparam logic CFG_SEL_CONN  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// rtl/lut_table_ram.sv - single-port synchronous-read truth-table RAM (contents not reset)
module lut_table_ram
    import lut_sched_pkg::*;
#(
    parameter int ADDR_W = NW_DEF + AW_DEF,
    parameter int DATA_W = OUT_W_DEF,
    parameter int DEPTH  = NEURONS_DEF << AW_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/lut_layer_sched.sv
// rtl/lut_layer_sched.sv - time-multiplexed LogicNet layer evaluator, one LUT lookup per cycle
// Optional perf counters (perf_samples, perf_stall) under LUT_SCHED_PERF_EN.
module lut_layer_sched
    import lut_sched_pkg::*;
#(
    parameter int NEURONS = NEURONS_DEF,
    parameter int FEATS   = FEATS_DEF,
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int FANIN   = FANIN_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    localparam int AW  = FANIN * FEAT_W,
    localparam int NW  = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int IW  = (FEATS > 1) ? $clog2(FEATS) : 1,
    localparam int SW  = (FANIN > 1) ? $clog2(FANIN) : 1,
    localparam int CAW = NW + AW,
    localparam int CDW = max_int(OUT_W, IW)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FEATS*FEAT_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NEURONS*OUT_W-1:0]  out_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_sel,
    input  logic [CAW-1:0]            cfg_addr,
    input  logic [CDW-1:0]            cfg_data
`ifdef LUT_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_samples,
    output logic [31:0]               perf_stall
`endif
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NW-1:0]              r_cnt;
    logic [FEATS*FEAT_W-1:0]    r_sample;
    logic [IW-1:0]              r_conn [NEURONS][FANIN];
    logic                       r_rd_vld;
    logic [NW-1:0]              r_rd_slot;
    logic                       r_last_cap;
    logic [NEURONS*OUT_W-1:0]   r_out_data;

    logic                       w_in_fire;
    logic                       w_cfg_fire;
    logic                       w_tbl_wr;
    logic                       w_conn_wr;
    logic [SW-1:0]              w_conn_slot;
    logic [NW-1:0]              w_conn_nrn;
    logic [AW-1:0]              w_gather;
    logic [CAW-1:0]             w_ram_addr;
    logic [OUT_W-1:0]           w_ram_rdata;

    // Held low through reset so neither master sees a handshake while rst_n is asserted.
    assign cfg_ready  = rst_n && (r_state == S_IDLE);
    assign in_ready   = cfg_ready && !cfg_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_tbl_wr   = w_cfg_fire && (cfg_sel == CFG_SEL_TABLE);
    assign w_conn_wr  = w_cfg_fire && (cfg_sel == CFG_SEL_CONN);
    assign w_conn_slot = cfg_addr[SW-1:0];
    assign w_conn_nrn  = cfg_addr[SW +: NW];

    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire)                     w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == NW'(NEURONS - 1))     w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_last_cap)                    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)                     w_state_nxt = S_IDLE;
            default:                                    w_state_nxt = S_IDLE;
        endcase
    end

    // Index compare instead of a variable part-select keeps unmatched indices (>= FEATS) at zero.
    always_comb begin
        w_gather = '0;
        for (int j = 0; j < FANIN; j++) begin
            for (int f = 0; f < FEATS; f++) begin
                if (r_conn[r_cnt][j] == IW'(f)) begin
                    w_gather[j*FEAT_W +: FEAT_W] = r_sample[f*FEAT_W +: FEAT_W];
                end
            end
        end
    end

    assign w_ram_addr = w_tbl_wr ? cfg_addr : {r_cnt, w_gather};

    lut_table_ram #(
        .ADDR_W (CAW),
        .DATA_W (OUT_W),
        .DEPTH  (NEURONS << AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_tbl_wr),
        .i_addr  (w_ram_addr),
        .i_wdata (cfg_data[OUT_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_sample <= in_data;
                r_cnt    <= '0;
            end else if (r_state == S_RUN && r_cnt != NW'(NEURONS - 1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Read-data pipeline: the slot tag follows the issue by one cycle to match RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_slot  <= '0;
            r_last_cap <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_rd_vld   <= (r_state == S_RUN);
            r_rd_slot  <= r_cnt;
            r_last_cap <= r_rd_vld && (r_rd_slot == NW'(NEURONS - 1));
            if (r_rd_vld) begin
                for (int n = 0; n < NEURONS; n++) begin
                    if (r_rd_slot == NW'(n)) begin
                        r_out_data[n*OUT_W +: OUT_W] <= w_ram_rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURONS; n++) begin
                for (int j = 0; j < FANIN; j++) begin
                    r_conn[n][j] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < NEURONS; n++) begin
                for (int j = 0; j < FANIN; j++) begin
                    if (w_conn_wr && w_conn_nrn == NW'(n) && w_conn_slot == SW'(j)) begin
                        r_conn[n][j] <= cfg_data[IW-1:0];
                    end
                end
            end
        end
    end

`ifdef LUT_SCHED_PERF_EN
    logic [31:0] r_perf_samples;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_samples <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (r_state == S_DONE && out_ready) begin
                r_perf_samples <= r_perf_samples + 32'd1;
            end
            if (r_state == S_DONE && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_samples = r_perf_samples;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
// tb/tb_lut_layer_sched.sv - scoreboard bench for lut_layer_sched (perf checks under LUT_SCHED_PERF_EN)
module tb_lut_layer_sched;

    localparam int NEURONS = 8;
    localparam int FEATS   = 16;
    localparam int FANIN   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_sel = 1'b0;
    logic [8:0]  cfg_addr = '0;
    logic [3:0]  cfg_data = '0;
`ifdef LUT_SCHED_PERF_EN
    logic [31:0] perf_samples;
    logic [31:0] perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  m_tbl [NEURONS][64];
    int          m_conn [NEURONS][FANIN];
    logic [15:0] m_q [$];

    always #5 clk = ~clk;

    lut_layer_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
`ifdef LUT_SCHED_PERF_EN
        ,
        .perf_samples (perf_samples),
        .perf_stall   (perf_stall)
`endif
    );

    function automatic logic [5:0] addr_of(input int n, input logic [31:0] s);
        logic [5:0] a;
        a = '0;
        for (int j = 0; j < FANIN; j++) begin
            if (m_conn[n][j] < FEATS) a[j*2 +: 2] = s[m_conn[n][j]*2 +: 2];
        end
        return a;
    endfunction

    function automatic logic [15:0] golden(input logic [31:0] s);
        logic [15:0] g;
        g = '0;
        for (int n = 0; n < NEURONS; n++) g[n*2 +: 2] = m_tbl[n][addr_of(n, s)];
        return g;
    endfunction

    task automatic cfg_write(input logic sel, input int addr, input int data);
        int w;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 9'(addr);
        cfg_data  = 4'(data);
        w = 0;
        while (!cfg_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w == 64) begin
            n_vec++; n_err++;
            $display("FAIL cfg_write_timeout: cfg_ready got 0 want 1 (addr %0d)", addr);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        if (sel == 1'b0) m_tbl[addr / 64][addr % 64] = 2'(data);
        else if ((addr % 4) < FANIN) m_conn[addr / 4][addr % 4] = data;
    endtask

    task automatic send_sample(input logic [31:0] s);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = s;
        w = 0;
        while (!in_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w == 64) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        m_q.push_back(golden(s));
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = $urandom;
    endtask

    task automatic wait_output(input bit bp, output logic [15:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                got = out_data;
                ok  = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_cfg_ready: got %b want 1", cfg_ready); end
`ifdef LUT_SCHED_PERF_EN
        n_vec++; if (perf_samples !== 32'd0 || perf_stall !== 32'd0) begin
            n_err++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_samples, perf_stall);
        end
`endif
    endtask

    task automatic load_config();
        for (int n = 0; n < NEURONS; n++)
            for (int l = 0; l < 64; l++) cfg_write(1'b0, n*64 + l, int'($urandom_range(0, 3)));
        for (int n = 0; n < NEURONS; n++)
            for (int j = 0; j < FANIN; j++) cfg_write(1'b1, n*4 + j, int'($urandom_range(0, 15)));
    endtask

`ifdef LUT_SCHED_PERF_EN
    task automatic test_perf();
        logic [15:0] got;
        logic [15:0] exp;
        for (int i = 0; i < 5; i++) begin
            send_sample($urandom);
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
            got = out_data;
            @(posedge clk);
            #1 out_ready = 1'b0;
            exp = m_q.pop_front();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL perf_data: got %h want %h", got, exp); end
        end
        @(negedge clk);
        n_vec++; if (perf_samples !== 32'd5) begin n_err++; $display("FAIL perf_samples: got %0d want 5", perf_samples); end
        n_vec++; if (perf_stall !== 32'd15) begin n_err++; $display("FAIL perf_stall: got %0d want 15", perf_stall); end
    endtask
`endif

    task automatic test_single_lookup();
        logic [31:0] s;
        logic [15:0] exp;
        int edges;
        cfg_write(1'b1, 0, 2);
        cfg_write(1'b1, 1, 5);
        cfg_write(1'b1, 2, 9);
        cfg_write(1'b0, 4, 2);
        s = $urandom;
        s[5:4] = 2'd0;
        s[11:10] = 2'd1;
        s[19:18] = 2'd0;
        send_sample(s);
        edges = 0;
        do begin
            @(posedge clk);
            #1 edges++;
        end while (!out_valid && edges < 50);
        n_vec++; if (edges != 10) begin n_err++; $display("FAIL single_latency: got %0d want 10", edges); end
        n_vec++; if (out_data[1:0] !== 2'b10) begin n_err++; $display("FAIL single_slot0: got %b want 10", out_data[1:0]); end
        exp = m_q.pop_front();
        n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL single_full: got %h want %h", out_data, exp); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_full_layer();
        logic [15:0] got;
        logic [15:0] exp;
        bit ok;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_sample($urandom);
            wait_output(1'b1, got, ok);
            exp = m_q.pop_front();
            n_vec++; if (!ok || got !== exp) begin
                n_err++; $display("FAIL full_layer[%0d]: got %h (ok %0d) want %h", i, got, ok, exp);
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_dup: out_valid got %b want 0", out_valid); end
        n_vec++; if (m_q.size() != 0) begin n_err++; $display("FAIL full_pending: got %0d want 0", m_q.size()); end
    endtask

    task automatic test_cfg_collision();
        logic [31:0] s;
        logic [5:0]  a0;
        logic [1:0]  v;
        logic [15:0] got;
        logic [15:0] exp;
        bit ok;
        s  = $urandom;
        a0 = addr_of(0, s);
        v  = ~m_tbl[0][a0];
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd0, a0}; cfg_data = {2'b00, v};
        in_valid  = 1'b1; in_data = s;
        #1;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL coll_cfg_ready: got %b want 1", cfg_ready); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL coll_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        m_tbl[0][a0] = v;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_in_next: got %b want 1", in_ready); end
        m_q.push_back(golden(s));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_output(1'b0, got, ok);
        exp = m_q.pop_front();
        n_vec++; if (!ok || got !== exp) begin n_err++; $display("FAIL coll_data: got %h want %h", got, exp); end
    endtask

    task automatic test_cfg_during_run();
        logic [31:0] s;
        logic [5:0]  a7;
        logic [1:0]  v;
        logic [15:0] got;
        logic [15:0] exp;
        bit ok;
        bit early;
        int w;
        s  = $urandom;
        a7 = addr_of(7, s);
        v  = ~m_tbl[7][a7];
        send_sample(s);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd7, a7}; cfg_data = {2'b00, v};
        early = 1'b0; ok = 1'b0; got = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cfg_ready) early = 1'b1;
            if (out_valid) begin
                got = out_data; ok = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                break;
            end
        end
        exp = m_q.pop_front();
        n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL run_cfg_ready: got 1 want 0 while busy"); end
        n_vec++; if (!ok || got !== exp) begin n_err++; $display("FAIL run_inflight: got %h want %h", got, exp); end
        w = 0;
        @(negedge clk);
        while (!cfg_ready && w < 20) begin @(negedge clk); w++; end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL run_cfg_idle: got %b want 1", cfg_ready); end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        m_tbl[7][a7] = v;
        send_sample(s);
        wait_output(1'b0, got, ok);
        exp = m_q.pop_front();
        n_vec++; if (!ok || got !== exp) begin n_err++; $display("FAIL run_after_write: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] got;
        logic [15:0] exp;
        bit ok;
        send_sample($urandom);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrun_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrun_in_ready: got %b want 0", in_ready); end
        void'(m_q.pop_back());
        for (int n = 0; n < NEURONS; n++) for (int j = 0; j < FANIN; j++) m_conn[n][j] = 0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrun_idle: in_ready got %b want 1", in_ready); end
        send_sample($urandom);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL done_rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL done_rst_out_data: got %h want 0000", out_data); end
        void'(m_q.pop_back());
        @(negedge clk) rst_n = 1'b1;
        send_sample($urandom);
        wait_output(1'b1, got, ok);
        exp = m_q.pop_front();
        n_vec++; if (!ok || got !== exp) begin n_err++; $display("FAIL fresh_after_rst: got %h want %h", got, exp); end
    endtask

    initial begin
        test_reset();
        load_config();
`ifdef LUT_SCHED_PERF_EN
        test_perf();
`endif
        test_single_lookup();
        test_full_layer();
        test_cfg_collision();
        test_cfg_during_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
